frame_write_arbiter: RTL and testbench

//  Shares one 32-bit block-RAM write port between two frame producers (radar

---
 rtl/frame_write_arbiter_pkg.sv | 20 ++
 rtl/frame_write_arbiter_bank_tracker.sv | 74 +++++++
 rtl/frame_write_arbiter.sv | 134 +++++++++++++
 tb/tb_frame_write_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : frame_write_arbiter_pkg
// Brief   : Shared types and constants for the frame write arbiter.
// Revision: 1.0
// ============================================================================
package frame_write_arbiter_pkg;

    localparam int c_SRC_W    = 1;
    localparam int c_BANK_W   = 1;
    localparam int c_HOLD_DEF = 4;
    localparam int c_CNT_W    = 4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/frame_write_arbiter_bank_tracker.sv
`default_nettype none
// ============================================================================
// Module  : frame_write_arbiter_bank_tracker
// Brief   : Per-source ping-pong bank state: pending done, ready flags, ovf.
// Revision: 1.0
// ============================================================================
module frame_write_arbiter_bank_tracker (
    input  logic clk,
    input  logic rst,
    input  logic i_done,
    input  logic i_service_en,
    input  logic i_ack,
    input  logic i_ack_bank,
    input  logic i_ovf_clr,
    output logic o_service,
    output logic o_bank,
    output logic o_irq,
    output logic o_irq_bank,
    output logic o_ovf
);

    logic       r_pend;
    logic       r_bank;
    logic       r_ovf;
    logic [1:0] r_rdy;
    logic [1:0] w_rdy_nxt;
    logic       w_service;
    logic       w_other_rdy;
    logic       w_both_rdy;

    // A live pulse is serviced immediately so a grant in the same cycle
    // can never slip ahead of the end-of-frame marker.
    assign w_service   = i_service_en & (r_pend | i_done);
    assign w_other_rdy = r_rdy[~r_bank];
    assign w_both_rdy  = r_rdy[r_bank] & w_other_rdy;

    always_comb begin
        w_rdy_nxt = r_rdy;
        if (i_ack) begin
            w_rdy_nxt[i_ack_bank] = 1'b0;
        end
        if (w_service) begin
            w_rdy_nxt[r_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= 1'b0;
            r_bank <= 1'b0;
            r_ovf  <= 1'b0;
            r_rdy  <= 2'b00;
        end else begin
            r_pend <= w_service ? 1'b0 : (r_pend | i_done);
            r_rdy  <= w_rdy_nxt;
            if (w_service && !w_other_rdy) begin
                r_bank <= ~r_bank;
            end
            if (w_service && w_both_rdy) begin
                r_ovf <= 1'b1;
            end else if (i_ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign o_service  = w_service;
    assign o_bank     = r_bank;
    assign o_irq      = |r_rdy;
    assign o_irq_bank = w_other_rdy ? ~r_bank : r_bank;
    assign o_ovf      = r_ovf;

endmodule
`default_nettype wire

// File: rtl/frame_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : frame_write_arbiter
// Brief   : Round-robin sharing of one BRAM write port between two producers.
// Revision: 1.0
// ============================================================================
module frame_write_arbiter
    import frame_write_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 32,
    parameter int HOLD_CYC = c_HOLD_DEF
) (
    input  logic                aclk,
    input  logic                rst,
    input  logic                s0_wr_req,
    output logic                s0_wr_gnt,
    input  logic [DATA_W-1:0]   s0_wr_data,
    input  logic [ADDR_W-1:0]   s0_wr_addr,
    input  logic                s0_frame_done,
    input  logic                s1_wr_req,
    output logic                s1_wr_gnt,
    input  logic [DATA_W-1:0]   s1_wr_data,
    input  logic [ADDR_W-1:0]   s1_wr_addr,
    input  logic                s1_frame_done,
    output logic [1:0]          irq,
    output logic [1:0]          irq_bank,
    input  logic [1:0]          irq_ack,
    input  logic [1:0]          ack_bank,
    output logic [1:0]          ovf,
    input  logic                ovf_clr,
    output logic                bram_en,
    output logic [3:0]          bram_we,
    output logic [ADDR_W+1:0]   bram_addr,
    output logic [DATA_W-1:0]   bram_wdata
);

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(HOLD_CYC - 1);

    arb_state_t              r_state;
    arb_state_t              w_state_nxt;
    logic [c_CNT_W-1:0]      r_cnt;
    logic [c_SRC_W-1:0]      r_last_gnt;
    logic                    r_bram_en;
    logic [ADDR_W+1:0]       r_bram_addr;
    logic [DATA_W-1:0]       r_bram_wdata;
    logic [1:0]              w_gnt;
    logic [c_SRC_W-1:0]      w_src;
    logic [1:0]              w_service;
    logic [1:0]              w_bank;
    logic [1:0]              w_done;
    logic                    w_idle;

    assign w_idle = (r_state == ST_IDLE);
    assign w_done = {s1_frame_done, s0_frame_done};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_tracker
            frame_write_arbiter_bank_tracker u_trk (
                .clk          (aclk),
                .rst          (rst),
                .i_done       (w_done[gi]),
                .i_service_en (w_idle),
                .i_ack        (irq_ack[gi]),
                .i_ack_bank   (ack_bank[gi]),
                .i_ovf_clr    (ovf_clr),
                .o_service    (w_service[gi]),
                .o_bank       (w_bank[gi]),
                .o_irq        (irq[gi]),
                .o_irq_bank   (irq_bank[gi]),
                .o_ovf        (ovf[gi])
            );
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        w_gnt       = 2'b00;
        w_src       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Frame-done servicing takes the cycle so the bank flip lands
                // before the next frame's first word is granted.
                if (!rst && (w_service == 2'b00) && (s0_wr_req || s1_wr_req)) begin
                    w_src       = (s0_wr_req && s1_wr_req) ? ~r_last_gnt : s1_wr_req;
                    w_gnt       = w_src ? 2'b10 : 2'b01;
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_last_gnt   <= 1'b1;
            r_bram_en    <= 1'b0;
            r_bram_addr  <= '0;
            r_bram_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_gnt != 2'b00) begin
                r_bram_en    <= 1'b1;
                r_cnt        <= '0;
                r_last_gnt   <= w_src;
                r_bram_addr  <= {w_src, w_bank[w_src], (w_src ? s1_wr_addr : s0_wr_addr)};
                r_bram_wdata <= w_src ? s1_wr_data : s0_wr_data;
            end else if (r_state == ST_WRITE) begin
                if (r_cnt == c_CNT_LAST) begin
                    r_bram_en <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign s0_wr_gnt  = w_gnt[0];
    assign s1_wr_gnt  = w_gnt[1];
    assign bram_en    = r_bram_en;
    assign bram_we    = {4{r_bram_en}};
    assign bram_addr  = r_bram_addr;
    assign bram_wdata = r_bram_wdata;

endmodule
`default_nettype wire

// File: tb/tb_frame_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_frame_write_arbiter
// Brief   : Directed scenarios plus randomized traffic against a cycle model.
// Revision: 1.0
// ============================================================================
module tb_frame_write_arbiter;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 32;
    localparam int HOLD   = 4;

    logic              aclk = 1'b0;
    logic              rst  = 1'b1;
    logic              s0_wr_req, s1_wr_req, s0_wr_gnt, s1_wr_gnt;
    logic [DATA_W-1:0] s0_wr_data, s1_wr_data, bram_wdata;
    logic [ADDR_W-1:0] s0_wr_addr, s1_wr_addr;
    logic              s0_frame_done, s1_frame_done, ovf_clr, bram_en;
    logic [1:0]        irq, irq_bank, irq_ack, ack_bank, ovf;
    logic [3:0]        bram_we;
    logic [ADDR_W+1:0] bram_addr;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 aclk = ~aclk;

    frame_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .HOLD_CYC(HOLD)) dut (
        .aclk(aclk), .rst(rst),
        .s0_wr_req(s0_wr_req), .s0_wr_gnt(s0_wr_gnt), .s0_wr_data(s0_wr_data),
        .s0_wr_addr(s0_wr_addr), .s0_frame_done(s0_frame_done),
        .s1_wr_req(s1_wr_req), .s1_wr_gnt(s1_wr_gnt), .s1_wr_data(s1_wr_data),
        .s1_wr_addr(s1_wr_addr), .s1_frame_done(s1_frame_done),
        .irq(irq), .irq_bank(irq_bank), .irq_ack(irq_ack), .ack_bank(ack_bank),
        .ovf(ovf), .ovf_clr(ovf_clr),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_wdata(bram_wdata)
    );

    task automatic clear_inputs();
        s0_wr_req = 0; s1_wr_req = 0; s0_wr_data = '0; s1_wr_data = '0;
        s0_wr_addr = '0; s1_wr_addr = '0; s0_frame_done = 0; s1_frame_done = 0;
        irq_ack = 2'b00; ack_bank = 2'b00; ovf_clr = 0;
    endtask

    task automatic do_reset();
        @(negedge aclk); rst = 1; clear_inputs();
        @(negedge aclk);
        @(negedge aclk); rst = 0;
    endtask

    task automatic test_reset();
        clear_inputs(); rst = 1; s0_wr_req = 1; s1_wr_req = 1;
        repeat (2) @(negedge aclk);
        #1;
        n_checks++;
        if ({s1_wr_gnt, s0_wr_gnt, bram_en, bram_we, irq, irq_bank, ovf} !== 13'd0)
            $display("FAIL reset_ctrl: got %b exp 0", {s1_wr_gnt, s0_wr_gnt, bram_en, bram_we, irq, irq_bank, ovf});
        else n_pass++;
        n_checks++;
        if ({bram_addr, bram_wdata} !== '0)
            $display("FAIL reset_data: got addr %h data %h exp 0", bram_addr, bram_wdata);
        else n_pass++;
        @(negedge aclk); rst = 0; clear_inputs();
    endtask

    task automatic test_single();
        do_reset();
        @(negedge aclk); s0_wr_req = 1; s0_wr_addr = 15'h010; s0_wr_data = 32'hC6230121;
        #1;
        n_checks++;
        if ({s1_wr_gnt, s0_wr_gnt} !== 2'b01) $display("FAIL single_gnt: got %b exp 01", {s1_wr_gnt, s0_wr_gnt});
        else n_pass++;
        for (int k = 1; k <= 5; k++) begin
            @(negedge aclk); s0_wr_req = 0;
            #1;
            n_checks++;
            if ({bram_en, bram_we} !== ((k <= HOLD) ? 5'b11111 : 5'b00000))
                $display("FAIL single_hold_%0d: got en %b we %h", k, bram_en, bram_we);
            else n_pass++;
            if (k <= HOLD) begin
                n_checks++;
                if (bram_addr !== 17'h00010 || bram_wdata !== 32'hC6230121)
                    $display("FAIL single_word_%0d: got addr %h data %h exp 00010 C6230121", k, bram_addr, bram_wdata);
                else n_pass++;
            end
        end
    endtask

    task automatic test_alternation();
        logic [1:0] exp_g;
        int w;
        do_reset();
        @(negedge aclk);
        s0_wr_req = 1; s1_wr_req = 1; s0_wr_data = 32'hA0000000; s1_wr_data = 32'hB0000000;
        s0_wr_addr = 15'h100; s1_wr_addr = 15'h200;
        for (int c = 0; c < 6 * (HOLD + 1); c++) begin
            if (c > 0) @(negedge aclk);
            #1;
            w = c / (HOLD + 1);
            exp_g = (c % (HOLD + 1) == 0) ? ((w % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
            n_checks++;
            if ({s1_wr_gnt, s0_wr_gnt} !== exp_g)
                $display("FAIL alt_gnt_c%0d: got %b exp %b", c, {s1_wr_gnt, s0_wr_gnt}, exp_g);
            else n_pass++;
            if (c % (HOLD + 1) == 1) begin
                n_checks++;
                if (bram_addr[16] !== w[0] || bram_wdata !== (w[0] ? 32'hB0000000 : 32'hA0000000))
                    $display("FAIL alt_word_%0d: got addr %h data %h", w, bram_addr, bram_wdata);
                else n_pass++;
            end
        end
        @(negedge aclk); clear_inputs();
    endtask

    task automatic test_frame_irq();
        do_reset();
        @(negedge aclk); s1_wr_req = 1; s1_wr_addr = 15'h040; s1_wr_data = 32'h11112222;
        #1;
        n_checks++;
        if (s1_wr_gnt !== 1'b1) $display("FAIL irq_first_gnt: got %b exp 1", s1_wr_gnt);
        else n_pass++;
        @(negedge aclk); s1_wr_req = 0;
        #1;
        n_checks++;
        if (bram_addr !== {1'b1, 1'b0, 15'h040}) $display("FAIL irq_first_addr: got %h exp 10040", bram_addr);
        else n_pass++;
        repeat (HOLD) @(negedge aclk);
        s1_frame_done = 1;
        @(negedge aclk); s1_frame_done = 0;
        #1;
        n_checks++;
        if (irq !== 2'b10 || irq_bank[1] !== 1'b0)
            $display("FAIL irq_raise: got irq %b bank %b exp irq 10 bank1 0", irq, irq_bank);
        else n_pass++;
        s1_wr_req = 1; s1_wr_addr = 15'h044;
        #1;
        n_checks++;
        if (s1_wr_gnt !== 1'b1) $display("FAIL irq_second_gnt: got %b exp 1", s1_wr_gnt);
        else n_pass++;
        @(negedge aclk); s1_wr_req = 0;
        #1;
        n_checks++;
        if (bram_addr !== {1'b1, 1'b1, 15'h044}) $display("FAIL irq_bank_swap: got %h exp 18044", bram_addr);
        else n_pass++;
        @(negedge aclk); irq_ack = 2'b10; ack_bank = 2'b00;
        @(negedge aclk); irq_ack = 2'b00;
        #1;
        n_checks++;
        if (irq[1] !== 1'b0) $display("FAIL irq_ack_clear: got %b exp 0", irq[1]);
        else n_pass++;
        repeat (HOLD) @(negedge aclk);
    endtask

    task automatic test_overflow();
        do_reset();
        for (int f = 1; f <= 3; f++) begin
            @(negedge aclk); s0_frame_done = 1;
            @(negedge aclk); s0_frame_done = 0;
            #1;
            n_checks++;
            if (irq[0] !== 1'b1 || irq_bank[0] !== 1'b0 || ovf[0] !== (f == 3))
                $display("FAIL ovf_frame_%0d: got irq %b bank %b ovf %b", f, irq[0], irq_bank[0], ovf[0]);
            else n_pass++;
        end
        s0_wr_req = 1; s0_wr_addr = 15'h008;
        @(negedge aclk); s0_wr_req = 0;
        #1;
        n_checks++;
        if (bram_addr !== {1'b0, 1'b1, 15'h008} || bram_en !== 1'b1)
            $display("FAIL ovf_bank_kept: got addr %h en %b exp 08008 1", bram_addr, bram_en);
        else n_pass++;
        repeat (HOLD) @(negedge aclk);
        ovf_clr = 1;
        @(negedge aclk); ovf_clr = 0;
        #1;
        n_checks++;
        if (ovf !== 2'b00) $display("FAIL ovf_clear: got %b exp 00", ovf);
        else n_pass++;
        s0_frame_done = 1; ovf_clr = 1;
        @(negedge aclk); s0_frame_done = 0; ovf_clr = 0;
        #1;
        n_checks++;
        if (ovf !== 2'b01) $display("FAIL ovf_beats_clr: got %b exp 01", ovf);
        else n_pass++;
    endtask

    task automatic test_ack_collision();
        do_reset();
        @(negedge aclk); s0_frame_done = 1;
        @(negedge aclk); s0_frame_done = 1; irq_ack = 2'b01; ack_bank = 2'b01;
        @(negedge aclk); s0_frame_done = 0; irq_ack = 2'b00; ack_bank = 2'b00;
        #1;
        n_checks++;
        if (irq[0] !== 1'b1 || irq_bank[0] !== 1'b0)
            $display("FAIL coll_both: got irq %b bank %b exp 1 0", irq[0], irq_bank[0]);
        else n_pass++;
        irq_ack = 2'b01; ack_bank = 2'b00;
        @(negedge aclk); irq_ack = 2'b00;
        #1;
        n_checks++;
        if (irq[0] !== 1'b1 || irq_bank[0] !== 1'b1)
            $display("FAIL coll_set_wins: got irq %b bank %b exp 1 1", irq[0], irq_bank[0]);
        else n_pass++;
        irq_ack = 2'b01; ack_bank = 2'b01;
        @(negedge aclk); irq_ack = 2'b00;
        #1;
        n_checks++;
        if (irq[0] !== 1'b0) $display("FAIL coll_final_ack: got %b exp 0", irq[0]);
        else n_pass++;
    endtask

    task automatic test_reset_midwrite();
        do_reset();
        @(negedge aclk); s0_wr_req = 1; s0_wr_data = 32'hDEADBEEF; s0_wr_addr = 15'h7FF;
        #1;
        n_checks++;
        if (s0_wr_gnt !== 1'b1) $display("FAIL mid_gnt: got %b exp 1", s0_wr_gnt);
        else n_pass++;
        @(negedge aclk); s0_wr_req = 0;
        @(negedge aclk); rst = 1;
        @(negedge aclk); rst = 0; s0_wr_req = 1; s1_wr_req = 1;
        #1;
        n_checks++;
        if ({bram_en, bram_we} !== 5'd0 || bram_addr !== '0 || bram_wdata !== '0)
            $display("FAIL mid_abort: got en %b we %h addr %h data %h exp 0", bram_en, bram_we, bram_addr, bram_wdata);
        else n_pass++;
        n_checks++;
        if ({s1_wr_gnt, s0_wr_gnt} !== 2'b01) $display("FAIL mid_tie_after_rst: got %b exp 01", {s1_wr_gnt, s0_wr_gnt});
        else n_pass++;
        @(negedge aclk); clear_inputs();
        repeat (HOLD) @(negedge aclk);
    endtask

    task automatic test_random();
        int          busy;
        bit          m_last, src, b, oth, cur;
        bit  [1:0]   m_bank, m_pend, m_ovf, hreq, fd, ack, ackb, svc, egnt, eirq, ebank;
        bit          m_rdy [2][2];
        bit          clr;
        logic [16:0] m_addr;
        logic [31:0] m_data;
        logic [14:0] haddr [2];
        logic [31:0] hdata [2];
        do_reset();
        busy = 0; m_last = 1; m_bank = 0; m_pend = 0; m_ovf = 0; hreq = 0;
        m_addr = '0; m_data = '0;
        for (int n = 0; n < 2; n++) begin
            m_rdy[n][0] = 0; m_rdy[n][1] = 0; haddr[n] = '0; hdata[n] = '0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge aclk);
            for (int n = 0; n < 2; n++) begin
                if (!hreq[n] && $urandom_range(0, 9) < 4) begin
                    hreq[n] = 1; haddr[n] = 15'($urandom); hdata[n] = $urandom;
                end
                fd[n]   = ($urandom_range(0, 11) == 0);
                ack[n]  = ($urandom_range(0, 7) == 0);
                ackb[n] = 1'($urandom);
            end
            clr = ($urandom_range(0, 31) == 0);
            s0_wr_req = hreq[0]; s0_wr_addr = haddr[0]; s0_wr_data = hdata[0];
            s1_wr_req = hreq[1]; s1_wr_addr = haddr[1]; s1_wr_data = hdata[1];
            s0_frame_done = fd[0]; s1_frame_done = fd[1];
            irq_ack = ack; ack_bank = ackb; ovf_clr = clr;

            for (int n = 0; n < 2; n++) begin
                svc[n]   = (busy == 0) && (m_pend[n] || fd[n]);
                eirq[n]  = m_rdy[n][0] | m_rdy[n][1];
                cur      = m_bank[n];
                ebank[n] = m_rdy[n][!cur] ? !cur : cur;
            end
            egnt = 2'b00; src = 0;
            if (busy == 0 && svc == 2'b00 && hreq != 2'b00) begin
                src = (hreq == 2'b11) ? !m_last : hreq[1];
                egnt[src] = 1'b1;
            end
            #1;
            n_checks++;
            if ({s1_wr_gnt, s0_wr_gnt} !== egnt)
                $display("FAIL rnd_gnt_c%0d: got %b exp %b", cyc, {s1_wr_gnt, s0_wr_gnt}, egnt);
            else n_pass++;
            n_checks++;
            if (bram_en !== (busy > 0) || bram_we !== ((busy > 0) ? 4'hF : 4'h0))
                $display("FAIL rnd_en_c%0d: got en %b we %h exp en %0d", cyc, bram_en, bram_we, busy > 0);
            else n_pass++;
            if (busy > 0) begin
                n_checks++;
                if (bram_addr !== m_addr || bram_wdata !== m_data)
                    $display("FAIL rnd_word_c%0d: got %h/%h exp %h/%h", cyc, bram_addr, bram_wdata, m_addr, m_data);
                else n_pass++;
            end
            n_checks++;
            if (irq !== eirq || (irq_bank & eirq) !== (ebank & eirq) || ovf !== m_ovf)
                $display("FAIL rnd_status_c%0d: got irq %b bank %b ovf %b exp %b %b %b",
                         cyc, irq, irq_bank, ovf, eirq, ebank, m_ovf);
            else n_pass++;

            if (egnt != 2'b00) begin
                m_addr = {src, m_bank[src], haddr[src]};
                m_data = hdata[src];
                m_last = src; hreq[src] = 0; busy = HOLD;
            end else if (busy > 0) begin
                busy--;
            end
            for (int n = 0; n < 2; n++) begin
                b   = m_bank[n];
                oth = m_rdy[n][!b];
                if (svc[n] && m_rdy[n][b] && oth) m_ovf[n] = 1;
                else if (clr) m_ovf[n] = 0;
                if (ack[n]) m_rdy[n][ackb[n]] = 0;
                if (svc[n]) begin
                    m_rdy[n][b] = 1;
                    if (!oth) m_bank[n] = !b;
                end
                m_pend[n] = svc[n] ? 1'b0 : (m_pend[n] | fd[n]);
            end
        end
        @(negedge aclk); clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        clear_inputs();
        test_reset();
        test_single();
        test_alternation();
        test_frame_irq();
        test_overflow();
        test_ack_collision();
        test_reset_midwrite();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
